// File: rtl/eq_seq_ctrl_pkg.sv
// Shared types and defaults for the equalizer sequencing controller.
package eq_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADDR_W_DEF = 10;
  localparam int DECIM_DEF  = 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    FAST = 2'd1,
    SLOW = 2'd2,
    DONE = 2'd3
  } state_e;

endpackage

// File: rtl/eq_seq_ctrl_if.sv
// Controller <-> codec strobe / queue / MAC datapath signal bundle.
interface eq_seq_ctrl_if #(
  parameter int DATA_W = eq_pkg::DATA_W_DEF,
  parameter int ADDR_W = eq_pkg::ADDR_W_DEF
) ();

  logic              smpl_vld;
  logic [DATA_W-1:0] smpl_in;
  logic              fq_seq;
  logic              sq_seq;
  logic              fq_wrt;
  logic              sq_wrt;
  logic [DATA_W-1:0] q_smpl;
  logic              mac_clr;
  logic              mac_en;
  logic [ADDR_W-1:0] coeff_addr;
  logic              sel_slow;
  logic              busy;
  logic              done;
  logic              overrun;
  logic              err;

  modport master (
    input  smpl_vld, smpl_in, fq_seq, sq_seq,
    output fq_wrt, sq_wrt, q_smpl, mac_clr, mac_en, coeff_addr,
           sel_slow, busy, done, overrun, err
  );

  modport slave (
    output smpl_vld, smpl_in, fq_seq, sq_seq,
    input  fq_wrt, sq_wrt, q_smpl, mac_clr, mac_en, coeff_addr,
           sel_slow, busy, done, overrun, err
  );

endinterface

// File: rtl/eq_seq_ctrl_phase.sv
// One queue replay phase: seen flag, coefficient counter, mac_en, end detect.
// Watchdog present only when SEQ_TIMEOUT_EN is defined.
module seq_phase #(
  parameter int ADDR_W = eq_pkg::ADDR_W_DEF
`ifdef SEQ_TIMEOUT_EN
  , parameter int SEQ_TIMEOUT = 8
`endif
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start_i,
  input  logic              active_i,
  input  logic              seq_i,
  output logic              mac_en_o,
  output logic              end_o,
  output logic              timeout_o,
  output logic [ADDR_W-1:0] addr_o
);

  logic              seen_q, seen_d;
  logic [ADDR_W-1:0] addr_q, addr_d;

  assign mac_en_o = active_i & seq_i;
  assign end_o    = active_i & seen_q & ~seq_i;
  assign addr_o   = addr_q;

  always_comb begin
    seen_d = seen_q;
    addr_d = addr_q;
    if (start_i) begin
      seen_d = 1'b0;
      addr_d = '0;
    end else if (active_i && seq_i) begin
      seen_d = 1'b1;
      addr_d = addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      seen_q <= 1'b0;
      addr_q <= '0;
    end else begin
      seen_q <= seen_d;
      addr_q <= addr_d;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(SEQ_TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;

  // Saturates on the last allowed cycle; a sequencing high there still wins.
  always_comb begin
    wd_d = wd_q;
    if (start_i)
      wd_d = '0;
    else if (active_i && !seen_q && wd_q != WD_W'(SEQ_TIMEOUT - 1))
      wd_d = wd_q + 1'b1;
  end

  assign timeout_o = active_i & ~seen_q & ~seq_i & (wd_q == WD_W'(SEQ_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) wd_q <= '0;
    else        wd_q <= wd_d;
  end
`else
  assign timeout_o = 1'b0;
`endif

endmodule

// File: rtl/eq_seq_ctrl.sv
// Equalizer sample sequencer: writes fast/slow queues and steers the shared MAC.
// Optional sequencing watchdog enabled by defining SEQ_TIMEOUT_EN.
module eq_seq_ctrl
  import eq_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DECIM  = DECIM_DEF
`ifdef SEQ_TIMEOUT_EN
  , parameter int SEQ_TIMEOUT = 8
`endif
) (
  input logic           clk,
  input logic           rst_n,
  eq_seq_ctrl_if.master bus
);

  localparam int DC_W = (DECIM > 1) ? $clog2(DECIM) : 1;

  state_e            state_q, state_d;
  logic [DATA_W-1:0] q_smpl_q, q_smpl_d;
  logic [DC_W-1:0]   decim_q, decim_d;
  logic              slow_pass_q, slow_pass_d;
  logic              used_slow_q, used_slow_d;
  logic              overrun_q, overrun_d;
  logic              fq_wrt_q, sq_wrt_q, mac_clr_q;

  logic              accept, go_slow;
  logic              fast_mac, fast_end, fast_to;
  logic              slow_mac, slow_end, slow_to;
  logic [ADDR_W-1:0] fast_addr, slow_addr;

  assign accept  = (state_q == IDLE) & bus.smpl_vld;
  assign go_slow = (state_q == FAST) & (state_d == SLOW);

  seq_phase #(
    .ADDR_W(ADDR_W)
`ifdef SEQ_TIMEOUT_EN
    , .SEQ_TIMEOUT(SEQ_TIMEOUT)
`endif
  ) u_fast (
    .clk(clk), .rst_n(rst_n), .start_i(accept), .active_i(state_q == FAST),
    .seq_i(bus.fq_seq), .mac_en_o(fast_mac), .end_o(fast_end),
    .timeout_o(fast_to), .addr_o(fast_addr)
  );

  seq_phase #(
    .ADDR_W(ADDR_W)
`ifdef SEQ_TIMEOUT_EN
    , .SEQ_TIMEOUT(SEQ_TIMEOUT)
`endif
  ) u_slow (
    .clk(clk), .rst_n(rst_n), .start_i(go_slow), .active_i(state_q == SLOW),
    .seq_i(bus.sq_seq), .mac_en_o(slow_mac), .end_o(slow_end),
    .timeout_o(slow_to), .addr_o(slow_addr)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (bus.smpl_vld) state_d = FAST;
      FAST: begin
        if (fast_to)       state_d = DONE;
        else if (fast_end) state_d = slow_pass_q ? SLOW : DONE;
      end
      SLOW:    if (slow_end || slow_to) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Slow-pass decision is frozen at acceptance so the counter can advance immediately.
  always_comb begin
    q_smpl_d    = q_smpl_q;
    decim_d     = decim_q;
    slow_pass_d = slow_pass_q;
    used_slow_d = used_slow_q;
    overrun_d   = overrun_q | ((state_q != IDLE) & bus.smpl_vld);
    if (accept) begin
      q_smpl_d    = bus.smpl_in;
      slow_pass_d = (decim_q == DC_W'(DECIM - 1));
      decim_d     = (decim_q == DC_W'(DECIM - 1)) ? '0 : decim_q + 1'b1;
      used_slow_d = 1'b0;
    end
    if (go_slow) used_slow_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_smpl_q    <= '0;
      decim_q     <= '0;
      slow_pass_q <= 1'b0;
      used_slow_q <= 1'b0;
      overrun_q   <= 1'b0;
      fq_wrt_q    <= 1'b0;
      sq_wrt_q    <= 1'b0;
      mac_clr_q   <= 1'b0;
    end else begin
      q_smpl_q    <= q_smpl_d;
      decim_q     <= decim_d;
      slow_pass_q <= slow_pass_d;
      used_slow_q <= used_slow_d;
      overrun_q   <= overrun_d;
      fq_wrt_q    <= accept;
      sq_wrt_q    <= go_slow;
      mac_clr_q   <= accept;
    end
  end

`ifdef SEQ_TIMEOUT_EN
  logic err_q, err_d;

  assign err_d = err_q | fast_to | slow_to;

  always_ff @(posedge clk) begin
    if (!rst_n) err_q <= 1'b0;
    else        err_q <= err_d;
  end
`endif

  // Address stays on the last-used counter through DONE/IDLE.
  always_comb begin
    bus.busy       = (state_q != IDLE);
    bus.done       = (state_q == DONE);
    bus.sel_slow   = (state_q == SLOW);
    bus.mac_en     = fast_mac | slow_mac;
    bus.coeff_addr = ((state_q == SLOW) || (state_q != FAST && used_slow_q)) ? slow_addr : fast_addr;
    bus.fq_wrt     = fq_wrt_q;
    bus.sq_wrt     = sq_wrt_q;
    bus.mac_clr    = mac_clr_q;
    bus.q_smpl     = q_smpl_q;
    bus.overrun    = overrun_q;
`ifdef SEQ_TIMEOUT_EN
    bus.err        = err_q;
`else
    bus.err        = 1'b0;
`endif
  end

endmodule

// File: tb/tb_eq_seq_ctrl.sv
// Randomized scoreboard bench for eq_seq_ctrl; per-pass expectations from a pass-level model.
module tb_eq_seq_ctrl;

  localparam int DATA_W      = 16;
  localparam int ADDR_W      = 10;
  localparam int DECIM       = 2;
  localparam int SEQ_TIMEOUT = 8;

  typedef struct {
    int smpl;
    int mac;
    int smac;
    int addr;
    int sq;
    int busy;
    int sel;
    int ovr;
    int err;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  eq_seq_ctrl_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  eq_seq_ctrl #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DECIM(DECIM)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t exp_q[$];
  exp_t mon_e;
  int   k, m_ovr, m_err;
  int   a_mac, a_smac, a_fq, a_sq, a_clr, a_busy, a_sel;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%0h) want %0d (0x%0h) at %0t", nm, act, act, exp, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic clr_acc;
    a_mac = 0; a_smac = 0; a_fq = 0; a_sq = 0; a_clr = 0; a_busy = 0; a_sel = 0;
  endtask

  // Monitor: accumulates per-pass activity and checks it against the queued expectation on done.
  always @(negedge clk) begin
    if (!rst_n) begin
      clr_acc();
    end else begin
      a_mac  += int'(bus.mac_en);
      a_smac += int'(bus.mac_en & bus.sel_slow);
      a_fq   += int'(bus.fq_wrt);
      a_sq   += int'(bus.sq_wrt);
      a_clr  += int'(bus.mac_clr);
      a_busy += int'(bus.busy);
      a_sel  += int'(bus.sel_slow);
      if (bus.done) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("q_smpl",     32'(bus.q_smpl),     mon_e.smpl);
          chk("mac_en_cnt", a_mac,               mon_e.mac);
          chk("slow_mac",   a_smac,              mon_e.smac);
          chk("coeff_addr", 32'(bus.coeff_addr), mon_e.addr);
          chk("fq_wrt_cnt", a_fq,                1);
          chk("sq_wrt_cnt", a_sq,                mon_e.sq);
          chk("mac_clr",    a_clr,               1);
          chk("busy_cyc",   a_busy,              mon_e.busy);
          chk("sel_slow",   a_sel,               mon_e.sel);
          chk("overrun",    32'(bus.overrun),    mon_e.ovr);
          chk("err",        32'(bus.err),        mon_e.err);
        end
        clr_acc();
      end
    end
  end

  task automatic wait_done(input int want, input string nm);
    int c;
    c = 0;
    while (c < 64) begin
      @(negedge clk);
      if (bus.done) break;
      tick();
      c++;
    end
    chk(nm, c, want);
    tick();
  endtask

  task automatic run_pass(input logic [15:0] d, input int fg, input int fh,
                          input int sg, input int sh, input bit inj);
    exp_t e;
    int   slow;
    slow = ((k % DECIM) == DECIM - 1) ? 1 : 0;
    k++;
    if (inj) m_ovr = 1;
    e.smpl = int'(d);
    e.mac  = fh + (slow != 0 ? sh : 0);
    e.smac = (slow != 0) ? sh : 0;
    e.addr = ((slow != 0) ? sh : fh) % (1 << ADDR_W);
    e.sq   = slow;
    e.sel  = (slow != 0) ? sg + sh + 1 : 0;
    e.busy = fg + fh + 1 + e.sel + 1;
    e.ovr  = m_ovr;
    e.err  = m_err;
    exp_q.push_back(e);

    bus.smpl_in  = d;
    bus.smpl_vld = 1'b1;
    tick();
    bus.smpl_vld = 1'b0;
    for (int i = 0; i < fg + fh; i++) begin
      bus.fq_seq   = (i >= fg);
      bus.sq_seq   = 1'($urandom_range(0, 1));
      bus.smpl_vld = inj && (i == fg + fh / 2);
      bus.smpl_in  = bus.smpl_vld ? 16'hBEEF : 16'($urandom);
      if (i == 0) begin
        @(negedge clk);
        chk("fq_wrt_n1",  32'(bus.fq_wrt),  1);
        chk("mac_clr_n1", 32'(bus.mac_clr), 1);
        chk("busy_n1",    32'(bus.busy),    1);
      end
      tick();
    end
    bus.fq_seq = 1'b0; bus.sq_seq = 1'b0; bus.smpl_vld = 1'b0;
    if (slow != 0) begin
      tick();
      for (int i = 0; i < sg + sh; i++) begin
        bus.sq_seq = (i >= sg);
        bus.fq_seq = 1'($urandom_range(0, 1));
        if (i == 0) begin
          @(negedge clk);
          chk("sq_wrt_first", 32'(bus.sq_wrt), 1);
        end
        tick();
      end
      bus.sq_seq = 1'b0; bus.fq_seq = 1'b0;
    end
    wait_done(1, "done_lat");
    repeat ($urandom_range(0, 2)) tick();
  endtask

  initial begin
    bus.smpl_vld = 1'b0; bus.smpl_in = '0; bus.fq_seq = 1'b0; bus.sq_seq = 1'b0;
    k = 0; m_ovr = 0; m_err = 0;
    clr_acc();
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy",  32'(bus.busy),       0);
    chk("rst_qsmpl", 32'(bus.q_smpl),     0);
    chk("rst_addr",  32'(bus.coeff_addr), 0);
    chk("rst_misc",  32'({bus.fq_wrt, bus.sq_wrt, bus.mac_clr, bus.mac_en, bus.sel_slow,
                          bus.done, bus.overrun, bus.err}), 0);
    tick();
    rst_n = 1'b1;

    run_pass(16'h1234, 2, 1021, 0, 0, 1'b0);
    run_pass(16'h0002, 1, 1021, 3, 1021, 1'b0);
    run_pass(16'h0777, 3, 50, 0, 0, 1'b1);
    for (int p = 0; p < 30; p++)
      run_pass(16'($urandom), $urandom_range(0, 6), $urandom_range(1, 20),
               $urandom_range(0, 6), $urandom_range(1, 20), ($urandom_range(0, 7) == 0));

`ifdef SEQ_TIMEOUT_EN
    begin
      exp_t e;
      k++;
      m_err  = 1;
      e.smpl = 16'h0C0C; e.mac = 0; e.smac = 0; e.addr = 0; e.sq = 0;
      e.sel  = 0; e.busy = SEQ_TIMEOUT + 1; e.ovr = m_ovr; e.err = 1;
      exp_q.push_back(e);
      bus.smpl_in = 16'h0C0C; bus.smpl_vld = 1'b1;
      tick();
      bus.smpl_vld = 1'b0;
      wait_done(SEQ_TIMEOUT, "timeout_lat");
    end
`else
    run_pass(16'h0C0C, 30, 3, 2, 3, 1'b0);
`endif
    for (int p = 0; p < 4; p++)
      run_pass(16'($urandom), $urandom_range(0, 6), $urandom_range(1, 12),
               $urandom_range(0, 6), $urandom_range(1, 12), 1'b0);

    bus.smpl_in = 16'h5A5A; bus.smpl_vld = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      bus.fq_seq   = 1'b1;
      bus.smpl_vld = (i == 50);
      bus.smpl_in  = (i == 50) ? 16'hBEEF : 16'h0000;
      tick();
    end
    bus.smpl_vld = 1'b0;
    @(negedge clk);
    chk("ovr_pre_rst",  32'(bus.overrun),    1);
    chk("addr_pre_rst", 32'(bus.coeff_addr), 100);
    rst_n = 1'b0;
    bus.fq_seq = 1'b0;
    tick();
    @(negedge clk);
    chk("midrst_busy", 32'(bus.busy),       0);
    chk("midrst_addr", 32'(bus.coeff_addr), 0);
    chk("midrst_ovr",  32'(bus.overrun),    0);
    chk("midrst_err",  32'(bus.err),        0);
    rst_n = 1'b1;
    k = 0; m_ovr = 0; m_err = 0;
    tick();

    for (int p = 0; p < 6; p++)
      run_pass(16'($urandom), $urandom_range(0, 6), $urandom_range(1, 12),
               $urandom_range(0, 6), $urandom_range(1, 12), 1'b0);

    repeat (3) tick();
    chk("exp_q_empty", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/eq_seq_ctrl.md
# eq_seq_ctrl

Sequencing controller for the equalizer's circular sample queues. It accepts each new audio sample and writes it into the fast queue; every DECIM-th sample it also writes the slow queue. While each queue replays its contents (its sequencing output), it steers the one shared MAC engine and coefficient ROM to that queue. It sits between the codec sample strobe and the fastQueue/slowQueue + MAC datapath.

## Interface
- DATA_W, 16, sample width
- ADDR_W, 10, coefficient address width
- DECIM, 2, slow-queue decimation ratio (≥2)
- SEQ_TIMEOUT, 8, cycles allowed from queue write to first sequencing high (used only with watchdog)
- clk  in  1  system clock; one clock domain
- rst_n  in  1  reset; synchronous, active-low
- smpl_vld  in  1  one-cycle strobe: smpl_in valid
- smpl_in  in  DATA_W  new sample
- fq_seq  in  1  fast queue sequencing
- sq_seq  in  1  slow queue sequencing
- fq_wrt  out  1  fast queue write strobe
- sq_wrt  out  1  slow queue write strobe
- q_smpl  out  DATA_W  sample presented to both queues
- mac_clr  out  1  clear accumulator
- mac_en  out  1  accumulate this cycle
- coeff_addr  out  ADDR_W  coefficient ROM address
- sel_slow  out  1  MAC operand mux: 1 = slow queue output
- busy  out  1  high in any state except IDLE
- done  out  1  one-cycle pulse: filter pass complete
- overrun  out  1  sticky: smpl_vld arrived while busy
- err  out  1  sticky: sequencing timeout

## Operation
- States: IDLE, FAST, SLOW, DONE.
- IDLE: on smpl_vld, latch smpl_in into q_smpl, pulse fq_wrt and mac_clr (next cycle), coeff_addr←0, go FAST.
- FAST: mac_en = fq_seq (combinational, FAST only). Each mac_en cycle, coeff_addr increments by 1 after the cycle. A seen flag sets on the first fq_seq high. When seen and fq_seq low: go SLOW if the decim count = DECIM-1, else DONE.
- FAST→SLOW: pulse sq_wrt with q_smpl unchanged, coeff_addr←0, sel_slow=1 for the whole SLOW state. No mac_clr; both passes sum into one accumulator.
- SLOW: same rules as FAST, using sq_seq. Exits to DONE.
- DONE: done=1 for one cycle, then IDLE.
- Decim counter: 0..DECIM-1. Advances once per accepted sample and wraps. Resets to 0, so sample 1 is fast-only and sample 2 is fast+slow for DECIM=2.
- smpl_vld while busy: sample is dropped and overrun sets. No state change.
- coeff_addr wraps modulo 2^ADDR_W.
- Reset mid-pass: everything returns to IDLE next edge. Outputs are not resumed.

## Timing
- Reset values: all outputs 0; q_smpl 0; state IDLE; decim count 0.
- smpl_vld sampled at edge N. fq_wrt, mac_clr and busy are high in cycle N+1.
- sq_wrt is high in the first SLOW cycle.
- done is high one cycle after the last sequencing-high cycle falls.
- mac_en has zero latency from fq_seq/sq_seq. The datapath aligns the queue output itself.
- The next sample is accepted no earlier than the cycle after done.

## Configuration
- SEQ_TIMEOUT_EN defined: a watchdog counts cycles in FAST/SLOW while seen=0. At SEQ_TIMEOUT it sets err and goes to DONE, and done still pulses.
- SEQ_TIMEOUT_EN undefined: the controller waits indefinitely, err is tied 0, and there is no watchdog logic.

## Structure
- Package eq_pkg: the state enum (IDLE/FAST/SLOW/DONE), DATA_W/ADDR_W defaults, the DECIM default.
- Sub-module seq_phase: one instance per queue, muxed by state. It holds the seen flag, the coeff counter, mac_en generation, the end-detect pulse and the optional watchdog.

## Test plan
- Reset: rst_n low 2 cycles → all outputs 0 and busy 0.
- Fast-only sample: smpl_vld with 0x1234, fq_seq high 1021 cycles → fq_wrt once, q_smpl=0x1234, 1021 mac_en, coeff_addr ends 1021 (0x3FD), done once, sq_wrt never.
- Second sample: smpl_vld with 0x0002, fq_seq high 1021, then sq_seq high 1021 → sq_wrt once after FAST, sel_slow high only in SLOW, 2042 mac_en total, a single mac_clr.
- Overrun: smpl_vld with 0xBEEF during FAST → overrun=1 and stays 1, q_smpl unchanged, pass completes normally.
- Timeout (SEQ_TIMEOUT_EN): fq_seq held low after a write → err=1 and done pulse 8 cycles after fq_wrt, then IDLE; without the macro, busy stays 1.
- Reset mid-FAST after 100 mac_en → next edge IDLE; coeff_addr, busy, overrun all 0.
